tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter MissLimit, default 2: consecutive missing frame_sync pulses at an expected slot-0 sample before lock is dropped; legal range 1..7.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 serial_in  input  1  time-multiplexed 4-slot bit stream (slot order 0,1,2,3), as produced by a 2-bit-select 4:1 mux.
REQ-005 sample_en  input  1  serial_in and frame_sync are valid this cycle; ignored when low.
REQ-006 frame_sync  input  1  marks the sample that belongs to slot 0; meaningful only with sample_en=1.
REQ-007 out  output  4  last complete frame; out[k] = slot-k bit.
REQ-008 out_valid  output  1  one-cycle pulse when out is updated.
REQ-009 slot  output  2  slot index the next accepted sample will be written to.
REQ-010 locked  output  1  high while state is LOCKED.
REQ-011 sync_err  output  1  one-cycle pulse on a misplaced frame_sync.

Function
REQ-012 Two states, HUNT and LOCKED; a "sample" means a rising edge with sample_en=1; all outputs registered.
REQ-013 HUNT: samples with frame_sync=0 discarded, slot held at 0; sample with frame_sync=1 written to slot 0, slot <= 1, state <= LOCKED, miss count <= 0.
REQ-014 LOCKED: each sample writes serial_in into shadow bit [slot], slot <= slot+1 mod 4 (3 wraps to 0).
REQ-015 Sample written to slot 3: out <= {serial_in, shadow[2:0]} and out_valid=1 on the same edge; out_valid low on every other edge.
REQ-016 Latency: out/out_valid visible the cycle after the edge that accepts the slot-3 sample.
REQ-017 out holds its value between frames; partial frames never reach out.
REQ-018 LOCKED, sample at slot 0 with frame_sync=1: accepted normally, miss count <= 0.
REQ-019 LOCKED, sample at slot 0 with frame_sync=0: miss count +1; if new count < MissLimit, sample accepted normally (flywheel).
REQ-020 If the new miss count = MissLimit: sample discarded, shadow cleared, slot <= 0, miss count <= 0, state <= HUNT, locked <= 0; no sync_err.
REQ-021 LOCKED, sample at slot 1..3 with frame_sync=1: sync_err=1 for one cycle, partial frame discarded (no out_valid), this sample written to slot 0, slot <= 1, miss count <= 0, stays LOCKED.
REQ-022 frame_sync with sample_en=0: no effect in any state.
REQ-023 sample_en gaps of any length leave slot, shadow, state and miss count unchanged.
REQ-024 Resync at REQ-021 and frame completion never coincide (resync sample is slot 0); out_valid and sync_err are never both high.

Reset
REQ-025 reset=1 at a rising edge: state <= HUNT; out <= 4'b0000; out_valid, sync_err, locked <= 0; slot <= 0; shadow, miss count <= 0.
REQ-026 Reset overrides all inputs on that edge, including mid-frame; partial frame discarded, no out_valid.
REQ-027 After reset deasserts, no out_valid until a frame_sync sample followed by three more samples.

Verification
REQ-028 Reset, then sample_en=1 every cycle, bits 1,0,1,1 with frame_sync on the first -> out=4'b1101, out_valid one cycle after 4th sample, locked=1 from the cycle after the 1st sample.
REQ-029 Locked, stream 0,1,1,0 with sample_en low for 3 cycles between slots 1 and 2 -> out=4'b0110 once, slot holds 2 through the gap.
REQ-030 Locked, frame_sync asserted on slot-2 sample -> sync_err pulse, no out_valid; next 3 samples 0,1,0 complete frame {0,1,0,sync-sample bit}.
REQ-031 MissLimit=2, locked, two consecutive frames with no frame_sync -> first frame completes via flywheel (out_valid), second slot-0 sample discarded, locked=0, slot=0.
REQ-032 Reset asserted after slot-2 sample -> next cycle all outputs zero, state HUNT; frame_sync-free samples afterwards produce no out_valid.
REQ-033 Back-to-back frames with continuous sample_en -> out_valid exactly every 4 cycles, out matches each frame.

Source files
------------

// File: rtl/tdm_demux.sv
// tdm_demux: recovers 4-slot frames from a time-multiplexed serial stream.
// A frame_sync-marked sample starts a frame in slot 0. Missing slot-0 syncs
// are bridged (flywheel) up to MissLimit-1 times before lock is dropped.
// A frame_sync seen in slots 1..3 restarts the frame at slot 0.
module tdm_demux #(
  parameter int MissLimit = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       sample_en,
  input  logic       frame_sync,
  output logic [3:0] out,
  output logic       out_valid,
  output logic [1:0] slot,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [0:0] S_HUNT   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  // Miss counter only needs to reach MissLimit (at most 7).
  localparam logic [3:0] MISS_LIM = 4'(MissLimit);

  logic [0:0] state_q,     state_d;
  logic [1:0] slot_q,      slot_d;
  logic [2:0] shadow_q,    shadow_d;
  logic [2:0] miss_q,      miss_d;
  logic [3:0] out_q,       out_d;
  logic       out_valid_q, out_valid_d;
  logic       sync_err_q,  sync_err_d;

  // Decoded per-sample conditions while locked.
  logic       at_slot0;
  logic       misplaced_sync;
  logic       missing_sync;
  logic [3:0] miss_inc;
  logic       miss_expired;

  // Classify the current sample relative to the expected frame position.
  always_comb begin
    at_slot0       = (slot_q == 2'd0);
    misplaced_sync = !at_slot0 && frame_sync;
    missing_sync   = at_slot0 && !frame_sync;
    miss_inc       = {1'b0, miss_q} + 4'd1;
    miss_expired   = missing_sync && (miss_inc >= MISS_LIM);
  end

  // Next-state logic: hunt for sync, then fill shadow slots and publish frames.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    shadow_d    = shadow_q;
    miss_d      = miss_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;

    if (sample_en) begin
      if (state_q == S_HUNT) begin
        // Only a sync-marked sample can start a frame; everything else is dropped.
        if (frame_sync) begin
          shadow_d = {2'b00, serial_in};
          slot_d   = 2'd1;
          miss_d   = 3'd0;
          state_d  = S_LOCKED;
        end
      end else begin
        if (miss_expired) begin
          // Too many consecutive missing syncs: give up lock silently.
          shadow_d = 3'b000;
          slot_d   = 2'd0;
          miss_d   = 3'd0;
          state_d  = S_HUNT;
        end else if (misplaced_sync) begin
          // Sync in mid-frame: abandon the partial frame and realign to slot 0.
          sync_err_d = 1'b1;
          shadow_d   = {2'b00, serial_in};
          slot_d     = 2'd1;
          miss_d     = 3'd0;
        end else begin
          // Normal accept (including flywheel over a tolerated missing sync).
          if (at_slot0) begin
            miss_d = frame_sync ? 3'd0 : miss_inc[2:0];
          end
          if (slot_q == 2'd3) begin
            out_d       = {serial_in, shadow_q};
            out_valid_d = 1'b1;
          end else begin
            shadow_d[slot_q] = serial_in;
          end
          slot_d = slot_q + 2'd1;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HUNT;
      slot_q      <= 2'd0;
      shadow_q    <= 3'b000;
      miss_q      <= 3'd0;
      out_q       <= 4'b0000;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      shadow_q    <= shadow_d;
      miss_q      <= miss_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign slot      = slot_q;
  assign locked    = (state_q == S_LOCKED);
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: each step drives one cycle, then outputs are
// compared #1 after the rising edge against hand-derived values.
module tb_tdm_demux;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       sample_en;
  logic       frame_sync;
  logic [3:0] out;
  logic       out_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;

  int checks   = 0;
  int failures = 0;

  tdm_demux #(.MissLimit(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .serial_in (serial_in),
    .sample_en (sample_en),
    .frame_sync(frame_sync),
    .out       (out),
    .out_valid (out_valid),
    .slot      (slot),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic fs, input logic b);
    sample_en  = en;
    frame_sync = fs;
    serial_in  = b;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] frames [3];

  initial begin
    reset = 1'b1; sample_en = 1'b0; frame_sync = 1'b0; serial_in = 1'b0;
    frames[0] = 4'b1001; frames[1] = 4'b0110; frames[2] = 4'b1110;

    // Reset state
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_out",    out,             4'b0000);
    chk("rst_ov",     {3'b0, out_valid}, 4'd0);
    chk("rst_slot",   {2'b0, slot},    4'd0);
    chk("rst_locked", {3'b0, locked},  4'd0);
    chk("rst_serr",   {3'b0, sync_err}, 4'd0);
    reset = 1'b0;

    // Hunt: unsynced samples and disabled sync are ignored
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("hunt_slot",   {2'b0, slot},   4'd0);
    chk("hunt_locked", {3'b0, locked}, 4'd0);
    step(1'b0, 1'b1, 1'b1);
    chk("fs_noen_locked", {3'b0, locked}, 4'd0);

    // First frame 1,0,1,1
    step(1'b1, 1'b1, 1'b1);
    chk("f1_locked", {3'b0, locked}, 4'd1);
    chk("f1_slot1",  {2'b0, slot},   4'd1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("f1_slot3", {2'b0, slot},      4'd3);
    chk("f1_ov_pre", {3'b0, out_valid}, 4'd0);
    step(1'b1, 1'b0, 1'b1);
    chk("f1_ov",   {3'b0, out_valid}, 4'd1);
    chk("f1_out",  out,               4'b1101);
    chk("f1_wrap", {2'b0, slot},      4'd0);

    // Frame 0,1,1,0 with a 3-cycle gap between slots 1 and 2
    step(1'b1, 1'b1, 1'b0);
    chk("gap_ov_drop", {3'b0, out_valid}, 4'd0);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("gap_slot", {2'b0, slot},      4'd2);
      chk("gap_ov",   {3'b0, out_valid}, 4'd0);
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("gap_ov_done", {3'b0, out_valid}, 4'd1);
    chk("gap_out",     out,               4'b0110);

    // Misplaced sync at slot 2 realigns; then 0,1,0 completes the frame
    step(1'b1, 1'b1, 1'b1);
    chk("rs_ov0", {3'b0, out_valid}, 4'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("rs_serr",   {3'b0, sync_err},  4'd1);
    chk("rs_ov",     {3'b0, out_valid}, 4'd0);
    chk("rs_slot",   {2'b0, slot},      4'd1);
    chk("rs_locked", {3'b0, locked},    4'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("rs_serr_pulse", {3'b0, sync_err}, 4'd0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("rs_ov_done", {3'b0, out_valid}, 4'd1);
    chk("rs_out",     out,               4'b0101);

    // Two frames without sync: flywheel once, then lock drops
    step(1'b1, 1'b0, 1'b1);
    chk("fw_locked", {3'b0, locked}, 4'd1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("fw_ov",  {3'b0, out_valid}, 4'd1);
    chk("fw_out", out,               4'b1011);
    step(1'b1, 1'b0, 1'b1);
    chk("drop_locked", {3'b0, locked},    4'd0);
    chk("drop_slot",   {2'b0, slot},      4'd0);
    chk("drop_ov",     {3'b0, out_valid}, 4'd0);
    chk("drop_serr",   {3'b0, sync_err},  4'd0);

    // Reset after slot-2 sample discards the partial frame
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("mr_slot3", {2'b0, slot}, 4'd3);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    chk("mr_out",    out,               4'b0000);
    chk("mr_ov",     {3'b0, out_valid}, 4'd0);
    chk("mr_locked", {3'b0, locked},    4'd0);
    chk("mr_slot",   {2'b0, slot},      4'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("mr_nosync_ov", {3'b0, out_valid}, 4'd0);
    end
    chk("mr_nosync_locked", {3'b0, locked}, 4'd0);

    // Back-to-back frames: out_valid exactly on every 4th sample
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        step(1'b1, (k == 0), frames[f][k]);
        chk("b2b_ov", {3'b0, out_valid}, {3'b0, (k == 3)});
        if (k == 3) chk("b2b_out", out, frames[f]);
      end
    end

    // Output holds between frames
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("hold_out", out,               4'b1110);
    chk("hold_ov",  {3'b0, out_valid}, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
